// File: rtl/cam_frame_wr.sv
`default_nettype none
// ============================================================================
// Module   : cam_frame_wr
// Purpose  : Frame-write stage after the 8-to-16-bit camera converter. Skips
//            settling frames, then writes one linear buffer per frame.
//            Optional macro CAM_FRAME_WR_CHECK_EN enables the geometry and
//            overflow checks that drive frame_err_o.
// Revision : 1.0 - initial release
// ============================================================================
module cam_frame_wr #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 10,
  parameter int ADDR_W      = 19
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              vsync_i,
  input  logic [15:0]       data_i,
  input  logic              data_de_i,
  input  logic              hblank_i,
  input  logic              capture_en_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              frame_start_o,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic [7:0]        frame_cnt_o
);

  localparam int                SKIP_W  = $clog2(SKIP_FRAMES + 2);
  localparam logic [SKIP_W-1:0] C_SKIP  = SKIP_W'(SKIP_FRAMES);
  // One extra bit so a buffer that exactly fills 2^ADDR_W can still flag "full"
  localparam logic [ADDR_W:0]   C_TOTAL = (ADDR_W+1)'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {
    S_SKIP      = 2'd0,
    S_WAIT_FALL = 2'd1,
    S_ACTIVE    = 2'd2
  } state_t;

  state_t            state_q;
  logic [SKIP_W-1:0] skip_cnt_q;
  logic [ADDR_W:0]   addr_q;
  logic              vsync_q;
  logic              vs_rise;
  logic              vs_fall;
  logic              addr_full;

  assign vs_rise   = vsync_i & ~vsync_q;
  assign vs_fall   = ~vsync_i & vsync_q;
  assign addr_full = (addr_q == C_TOTAL);

  // Edge history keeps tracking through reset so release never fakes an edge
  always_ff @(posedge pixel_clk) begin
    vsync_q <= vsync_i;
    if (rst) begin
      state_q       <= S_SKIP;
      skip_cnt_q    <= '0;
      addr_q        <= '0;
      wr_en_o       <= 1'b0;
      wr_addr_o     <= '0;
      wr_data_o     <= '0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      wr_en_o       <= 1'b0;
      frame_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      unique case (state_q)
        S_SKIP: begin
          if (skip_cnt_q == C_SKIP) begin
            state_q <= S_WAIT_FALL;
          end else if (vs_rise) begin
            skip_cnt_q <= skip_cnt_q + 1'b1;
          end
        end
        S_WAIT_FALL: begin
          if (vs_fall && capture_en_i) begin
            state_q       <= S_ACTIVE;
            addr_q        <= '0;
            frame_start_o <= 1'b1;
          end
        end
        S_ACTIVE: begin
          if (data_de_i && !addr_full) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= addr_q[ADDR_W-1:0];
            wr_data_o <= data_i;
            addr_q    <= addr_q + 1'b1;
          end
          if (vs_rise) begin
            frame_done_o <= 1'b1;
            frame_cnt_o  <= frame_cnt_o + 1'b1;
            state_q      <= S_WAIT_FALL;
          end
        end
        default: state_q <= S_SKIP;
      endcase
    end
  end

`ifdef CAM_FRAME_WR_CHECK_EN
  localparam logic [ADDR_W:0] C_H = (ADDR_W+1)'(H_ACTIVE);
  localparam logic [ADDR_W:0] C_V = (ADDR_W+1)'(V_ACTIVE);

  logic            hblank_q;
  logic            hb_fall;
  logic [ADDR_W:0] pix_cnt_q;
  logic [ADDR_W:0] pix_cnt_d;
  logic [ADDR_W:0] line_cnt_q;
  logic [ADDR_W:0] line_cnt_d;
  logic            err_q;

  assign hb_fall = ~hblank_i & hblank_q;

  // Counts include the current cycle's word/line so same-cycle events check correctly
  always_comb begin
    pix_cnt_d  = pix_cnt_q + {{ADDR_W{1'b0}}, data_de_i};
    line_cnt_d = line_cnt_q + {{ADDR_W{1'b0}}, hb_fall};
  end

  always_ff @(posedge pixel_clk) begin
    hblank_q <= hblank_i;
    if (rst) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (state_q == S_WAIT_FALL && vs_fall && capture_en_i) begin
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
    end else if (state_q == S_ACTIVE) begin
      if (data_de_i && addr_full) begin
        err_q <= 1'b1;
      end
      if (hb_fall) begin
        if (pix_cnt_d != C_H) begin
          err_q <= 1'b1;
        end
        pix_cnt_q <= '0;
      end else begin
        pix_cnt_q <= pix_cnt_d;
      end
      line_cnt_q <= line_cnt_d;
      if (vs_rise && line_cnt_d != C_V) begin
        err_q <= 1'b1;
      end
    end
  end

  assign frame_err_o = err_q;
`else
  logic unused_hblank;
  assign unused_hblank = hblank_i;
  assign frame_err_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cam_frame_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_frame_wr
// Purpose  : Directed scoreboard bench for cam_frame_wr (H=4, V=3, SKIP=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cam_frame_wr;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int SK = 2;
  localparam int AW = 19;
`ifdef CAM_FRAME_WR_CHECK_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b1;
  logic [15:0]   din = '0;
  logic          de = 1'b0;
  logic          hblank = 1'b0;
  logic          cap = 1'b1;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [15:0]   wr_data_o;
  logic          frame_start_o;
  logic          frame_done_o;
  logic          frame_err_o;
  logic [7:0]    frame_cnt_o;

  cam_frame_wr #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SK), .ADDR_W(AW)) dut (
    .pixel_clk    (clk),
    .rst          (rst),
    .vsync_i      (vsync),
    .data_i       (din),
    .data_de_i    (de),
    .hblank_i     (hblank),
    .capture_en_i (cap),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .frame_start_o(frame_start_o),
    .frame_done_o (frame_done_o),
    .frame_err_o  (frame_err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc     = 0;
  int   n_assert = 0;
  int   n_fail  = 0;
  int   n_start = 0;
  int   n_done  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every write must match the head of the scoreboard
  always @(negedge clk) begin
    if (frame_start_o) n_start++;
    if (frame_done_o)  n_done++;
    if (wr_en_o) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL write_unexpected: observed addr=%0d data=0x%0h, expected no write", wr_addr_o, wr_data_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_assert++;
        assert (wr_addr_o === AW'(e.addr) && wr_data_o === 16'(e.data) && cyc === e.cyc) else begin
          n_fail++;
          $error("FAIL write: observed addr=%0d data=0x%0h cyc=%0d, expected addr=%0d data=0x%0h cyc=%0d",
                 wr_addr_o, wr_data_o, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic vs);
    @(negedge clk);
    rst = 1'b1; vsync = vs; de = 1'b0; hblank = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic frame(input int nlines, input int short_idx, input int short_len, input logic cap_v,
                       input logic expect_cap, input int base, input int abort_after);
    int widx;
    int nw;
    widx = 0;
    n_start = 0;
    n_done  = 0;
    @(negedge clk);
    cap = cap_v; vsync = 1'b0;
    idle(2);
    for (int l = 0; l < nlines; l++) begin
      nw = (l == short_idx) ? short_len : H;
      for (int w = 0; w < nw; w++) begin
        @(negedge clk);
        hblank = 1'b1; de = 1'b1; din = 16'(base + widx);
        if (expect_cap && widx < H * V) sb.push_back('{widx, base + widx, cyc + 1});
        widx++;
        if (widx == abort_after) return;
      end
      @(negedge clk);
      de = 1'b0; hblank = 1'b0;
      idle(2);
    end
    vsync = 1'b1;
    idle(3);
  endtask

  task automatic post(input string tag, input int es, input int ed, input int ecnt, input logic eerr);
    chk({tag, "_start"}, n_start, es);
    chk({tag, "_done"},  n_done,  ed);
    chk({tag, "_cnt"},   frame_cnt_o, ecnt);
    chk({tag, "_err"},   frame_err_o, eerr);
    chk({tag, "_pending"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    // Phase A: skip, data path, short line with sticky error
    do_reset(1'b1);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_addr",  wr_addr_o, 0);
    chk("rst_data",  wr_data_o, 0);
    chk("rst_start", frame_start_o, 0);
    chk("rst_done",  frame_done_o, 0);
    chk("rst_err",   frame_err_o, 0);
    chk("rst_cnt",   frame_cnt_o, 0);
    frame(V, -1, 0, 1'b1, 1'b0, 16'h0100, -1);
    post("skip1", 0, 0, 0, 1'b0);
    frame(V, -1, 0, 1'b1, 1'b0, 16'h0200, -1);
    post("skip2", 0, 0, 0, 1'b0);
    frame(V, -1, 0, 1'b1, 1'b1, 16'h1000, -1);
    post("cap3", 1, 1, 1, 1'b0);
    chk("cap3_last_data", wr_data_o, 16'h100B);
    frame(V, 1, 3, 1'b1, 1'b1, 16'h1100, -1);
    post("short", 1, 1, 2, ERR_ON);
    frame(V, -1, 0, 1'b1, 1'b1, 16'h1200, -1);
    post("sticky", 1, 1, 3, ERR_ON);

    // Phase B: capture gating and overflow suppression
    do_reset(1'b1);
    chk("rst2_err", frame_err_o, 0);
    chk("rst2_cnt", frame_cnt_o, 0);
    frame(V, -1, 0, 1'b1, 1'b0, 16'h0300, -1);
    frame(V, -1, 0, 1'b1, 1'b0, 16'h0400, -1);
    post("skip_b", 0, 0, 0, 1'b0);
    frame(V, -1, 0, 1'b0, 1'b0, 16'h2000, -1);
    post("gated", 0, 0, 0, 1'b0);
    frame(V, -1, 0, 1'b1, 1'b1, 16'h2100, -1);
    post("ungated", 1, 1, 1, 1'b0);
    frame(V + 1, -1, 0, 1'b1, 1'b1, 16'h5000, -1);
    post("ovf", 1, 1, 2, ERR_ON);
    chk("ovf_data_hold", wr_data_o, 16'h500B);
    chk("ovf_addr_last", wr_addr_o, 11);

    // Phase C: reset in the middle of a captured frame
    do_reset(1'b1);
    frame(V, -1, 0, 1'b1, 1'b0, 16'h0500, -1);
    frame(V, -1, 0, 1'b1, 1'b0, 16'h0600, -1);
    frame(V, -1, 0, 1'b1, 1'b1, 16'h3000, 5);
    @(negedge clk);
    de = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; hblank = 1'b0;
    n_done = 0;
    chk("mid_wr_en", wr_en_o, 0);
    chk("mid_addr",  wr_addr_o, 0);
    chk("mid_data",  wr_data_o, 0);
    chk("mid_cnt",   frame_cnt_o, 0);
    chk("mid_err",   frame_err_o, 0);
    idle(2);
    vsync = 1'b1;
    idle(3);
    chk("mid_no_done", n_done, 0);
    chk("mid_pending", sb.size(), 0);
    frame(V, -1, 0, 1'b1, 1'b0, 16'h0700, -1);
    post("mid_skip", 0, 0, 0, 1'b0);
    frame(V, -1, 0, 1'b1, 1'b1, 16'h4000, -1);
    post("mid_resume", 1, 1, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
